// File: rtl/branch_cond_unit_pkg.sv
// Shared types and status-word bit positions for the branch condition unit.
package branch_cond_unit_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    BcuIdle  = 2'd0,
    BcuEval  = 2'd1,
    BcuIssue = 2'd2
  } bcu_state_e;

  localparam int unsigned FLAG_N_BIT = 31;
  localparam int unsigned FLAG_Z_BIT = 30;
  localparam int unsigned FLAG_C_BIT = 29;
  localparam int unsigned FLAG_V_BIT = 28;
  localparam int unsigned MODE_BIT   = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator; shared with predicated-execution logic.
// Optional feature: BCU_PRIV_CHECK_EN turns code F into "always, privileged".
module cond_eval
  import branch_cond_unit_pkg::*;
(
  input  cond_e cond,
  input  logic  n,
  input  logic  z,
  input  logic  c,
  input  logic  v,
  input  logic  mode,
  output logic  taken,
  output logic  fault
);

`ifndef BCU_PRIV_CHECK_EN
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    taken = 1'b0;
    fault = 1'b0;
    unique case (cond)
      CondEq: taken = z;
      CondNe: taken = !z;
      CondCs: taken = c;
      CondCc: taken = !c;
      CondMi: taken = n;
      CondPl: taken = !n;
      CondVs: taken = v;
      CondVc: taken = !v;
      CondHi: taken = c & !z;
      CondLs: taken = !c | z;
      CondGe: taken = (n == v);
      CondLt: taken = (n != v);
      CondGt: taken = !z & (n == v);
      CondLe: taken = z | (n != v);
      CondAl: taken = 1'b1;
      CondNv: begin
`ifdef BCU_PRIV_CHECK_EN
        taken = mode;
        fault = !mode;
`else
        taken = 1'b0;
`endif
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Multicycle branch condition resolver: IDLE -> EVAL (sample flags) -> ISSUE (handshake).
// Optional feature: BCU_PRIV_CHECK_EN enables the privileged code F and out_fault.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OFF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [OFF_W-1:0] req_off,
  input  logic             req_consume,
  input  logic             flush,
  input  logic [31:0]      status_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [PC_W-1:0]  out_target,
  output logic             out_fault,
  output logic [3:0]       clr_flag
);

  bcu_state_e state_q, state_d;

  logic [3:0]       cond_q;
  logic [PC_W-1:0]  pc_q;
  logic [OFF_W-1:0] off_q;
  logic             consume_q;
  logic             taken_q;
  logic [PC_W-1:0]  target_q;
  logic             eval_taken, eval_fault;
  logic [PC_W-1:0]  off_ext, target_d;
  logic             accept, handshake;

  logic unused_status;
  assign unused_status = ^status_reg[FLAG_V_BIT-1:MODE_BIT+1];

  assign accept    = (state_q == BcuIdle) && req_valid && !flush;
  assign handshake = (state_q == BcuIssue) && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BcuIdle:  if (accept) state_d = BcuEval;
      BcuEval:  state_d = BcuIssue;
      BcuIssue: if (out_ready) state_d = BcuIdle;
      default:  state_d = BcuIdle;
    endcase
    if (flush) state_d = BcuIdle;
  end

  cond_eval u_cond_eval (
    .cond  (cond_e'(cond_q)),
    .n     (status_reg[FLAG_N_BIT]),
    .z     (status_reg[FLAG_Z_BIT]),
    .c     (status_reg[FLAG_C_BIT]),
    .v     (status_reg[FLAG_V_BIT]),
    .mode  (status_reg[MODE_BIT]),
    .taken (eval_taken),
    .fault (eval_fault)
  );

  // Word offset, sign-extended then scaled to bytes; the sum wraps modulo 2^PC_W.
  assign off_ext  = PC_W'($signed(off_q));
  assign target_d = pc_q + PC_W'(4) + (off_ext << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BcuIdle;
      cond_q    <= 4'h0;
      pc_q      <= '0;
      off_q     <= '0;
      consume_q <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cond_q    <= req_cond;
        pc_q      <= req_pc;
        off_q     <= req_off;
        consume_q <= req_consume;
      end
      if (state_q == BcuEval && !flush) begin
        taken_q  <= eval_taken;
        target_q <= target_d;
      end
    end
  end

`ifdef BCU_PRIV_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (state_q == BcuEval && !flush) begin
      fault_q <= eval_fault;
    end
  end
  assign out_fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = eval_fault;
  assign out_fault    = 1'b0;
`endif

  assign req_ready  = (state_q == BcuIdle);
  assign out_valid  = (state_q == BcuIssue);
  assign out_taken  = taken_q;
  assign out_target = target_q;

  // A faulting branch is never taken, so it can never request a clear.
  always_comb begin
    clr_flag = 4'h0;
    if (handshake && !flush && consume_q && taken_q) clr_flag = 4'hF;
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit with a behavioural condition/target model.
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cond = 4'h0;
  logic [31:0] req_pc = 32'h0;
  logic [15:0] req_off = 16'h0;
  logic        req_consume = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] status_reg = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_fault;
  logic [3:0]  clr_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.PC_W(32), .OFF_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cond    (req_cond),
    .req_pc      (req_pc),
    .req_off     (req_off),
    .req_consume (req_consume),
    .flush       (flush),
    .status_reg  (status_reg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_taken   (out_taken),
    .out_target  (out_target),
    .out_fault   (out_fault),
    .clr_flag    (clr_flag)
  );

  // Reference decision straight from the condition-code table.
  function automatic void ref_decide(input logic [3:0] cc, input logic [31:0] st,
                                     output logic tk, output logic ft);
    bit n, z, c, v, m;
    n = st[31]; z = st[30]; c = st[29]; v = st[28]; m = st[0];
    ft = 1'b0;
    case (int'(cc))
      0:  tk = z;
      1:  tk = !z;
      2:  tk = c;
      3:  tk = !c;
      4:  tk = n;
      5:  tk = !n;
      6:  tk = v;
      7:  tk = !v;
      8:  tk = c && !z;
      9:  tk = !(c && !z);
      10: tk = (n == v);
      11: tk = (n != v);
      12: tk = !z && (n == v);
      13: tk = !(!z && (n == v));
      14: tk = 1'b1;
      default: begin
`ifdef BCU_PRIV_CHECK_EN
        tk = m;
        ft = !m;
`else
        tk = 1'b0;
`endif
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] off);
    int so;
    so = int'($signed(off));
    return pc + 32'd4 + 32'(so * 4);
  endfunction

  // Presents one request for a single cycle; st_eval is the flag value from the accept edge on.
  task automatic send_req(input logic [3:0] cc, input logic [31:0] pc, input logic [15:0] off,
                          input logic cons, input logic [31:0] st_eval, output logic rdy);
    @(negedge clk);
    req_cond = cc; req_pc = pc; req_off = off; req_consume = cons; req_valid = 1'b1;
    rdy = req_ready;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    status_reg = st_eval;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_tests++; if (clr_flag !== 4'h0) begin n_fail++; $display("FAIL rst_clr: got %h want 0", clr_flag); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_tests++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b want 0", out_taken); end
    n_tests++; if (out_target !== 32'h0) begin n_fail++; $display("FAIL rst_target: got %h want 0", out_target); end
    n_tests++; if (out_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", out_fault); end
  endtask

  task automatic test_basic;
    logic rdy;
    status_reg = 32'h4000_0000;
    send_req(4'h0, 32'h100, 16'd3, 1'b0, 32'h4000_0000, rdy);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", rdy); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_t1_valid: got %b want 0", out_valid); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_t2_valid: got %b want 1", out_valid); end
    n_tests++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL basic_taken: got %b want 1", out_taken); end
    n_tests++; if (out_target !== 32'h110) begin n_fail++; $display("FAIL basic_target: got %h want 110", out_target); end
    out_ready = 1'b1;
    #1;
    n_tests++; if (clr_flag !== 4'h0) begin n_fail++; $display("FAIL basic_clr: got %h want 0", clr_flag); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_all_codes;
    logic rdy, tk, ft, cons;
    logic [31:0] st, pc, exp_t;
    logic [15:0] off;
    bit got;
    out_ready = 1'b1;
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f++) begin
        pc   = $urandom;
        off  = 16'($urandom);
        cons = 1'($urandom);
        st   = {4'(f), 27'($urandom), 1'($urandom)};
        status_reg = $urandom;
        ref_decide(4'(cc), st, tk, ft);
        exp_t = ref_target(pc, off);
        send_req(4'(cc), pc, off, cons, st, rdy);
        wait_valid(got);
        n_tests++;
        if (!got || rdy !== 1'b1) begin
          n_fail++; $display("FAIL codes_valid c=%0d f=%0d: got %b rdy %b want 1", cc, f, got, rdy);
        end else begin
          n_tests++; if (out_taken !== tk) begin n_fail++;
            $display("FAIL codes_taken c=%0d f=%0d st=%h: got %b want %b", cc, f, st, out_taken, tk); end
          n_tests++; if (out_fault !== ft) begin n_fail++;
            $display("FAIL codes_fault c=%0d f=%0d: got %b want %b", cc, f, out_fault, ft); end
          n_tests++; if (out_target !== exp_t) begin n_fail++;
            $display("FAIL codes_target pc=%h off=%h: got %h want %h", pc, off, out_target, exp_t); end
          n_tests++; if (clr_flag !== ((cons && tk) ? 4'hF : 4'h0)) begin n_fail++;
            $display("FAIL codes_clr c=%0d: got %h want %h", cc, clr_flag, (cons && tk) ? 4'hF : 4'h0); end
        end
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flag_timing;
    logic rdy;
    bit got;
    out_ready = 1'b1;
    status_reg = 32'h0;
    send_req(4'h0, 32'h200, 16'd0, 1'b0, 32'h4000_0000, rdy);
    wait_valid(got);
    n_tests++; if (!got || out_taken !== 1'b1) begin n_fail++;
      $display("FAIL flag_late_set: got %b want 1", out_taken); end
    @(posedge clk); #1;
    status_reg = 32'h4000_0000;
    send_req(4'h0, 32'h200, 16'd0, 1'b0, 32'h0, rdy);
    wait_valid(got);
    n_tests++; if (!got || out_taken !== 1'b0) begin n_fail++;
      $display("FAIL flag_late_clear: got %b want 0", out_taken); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_stall_consume;
    logic rdy;
    send_req(4'hE, 32'h1000, 16'hFFFF, 1'b1, 32'h0, rdy);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h1000) begin
        n_fail++; $display("FAIL stall_hold %0d: got v=%b t=%b tgt=%h want 1 1 1000", i,
                           out_valid, out_taken, out_target); end
      n_tests++; if (clr_flag !== 4'h0) begin n_fail++;
        $display("FAIL stall_clr %0d: got %h want 0", i, clr_flag); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (clr_flag !== 4'hF) begin n_fail++; $display("FAIL consume_pulse: got %h want F", clr_flag); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++; if (clr_flag !== 4'h0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL consume_after: got clr=%h v=%b want 0 0", clr_flag, out_valid); end
    send_req(4'h1, 32'h1000, 16'h0, 1'b1, 32'h4000_0000, rdy);
    @(negedge clk); @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_tests++; if (clr_flag !== 4'h0 || out_taken !== 1'b0) begin n_fail++;
      $display("FAIL consume_not_taken: got clr=%h t=%b want 0 0", clr_flag, out_taken); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic rdy;
    bit got;
    out_ready = 1'b1;
    send_req(4'hE, 32'hFFFF_FFFC, 16'h0, 1'b0, 32'h0, rdy);
    wait_valid(got);
    n_tests++; if (!got || out_target !== 32'h0) begin n_fail++;
      $display("FAIL wrap_hi: got %h want 0", out_target); end
    @(posedge clk); #1;
    send_req(4'hE, 32'h10, 16'hFFFE, 1'b0, 32'h0, rdy);
    wait_valid(got);
    n_tests++; if (!got || out_target !== 32'h0C) begin n_fail++;
      $display("FAIL wrap_neg: got %h want c", out_target); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    logic rdy;
    bit seen;
    bit got;
    out_ready = 1'b1;
    send_req(4'hE, 32'h40, 16'h1, 1'b1, 32'h0, rdy);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_eval: got valid_seen=%b ready=%b want 0 1", seen, req_ready); end
    send_req(4'hE, 32'h40, 16'h1, 1'b0, 32'h0, rdy);
    wait_valid(got);
    n_tests++; if (rdy !== 1'b1 || !got || out_target !== 32'h48) begin n_fail++;
      $display("FAIL flush_next: got rdy=%b tgt=%h want 1 48", rdy, out_target); end
    @(posedge clk); #1;
    // Flush racing the handshake of a consuming, taken branch.
    out_ready = 1'b0;
    send_req(4'hE, 32'h40, 16'h1, 1'b1, 32'h0, rdy);
    @(negedge clk); @(negedge clk);
    out_ready = 1'b1; flush = 1'b1;
    #1;
    n_tests++; if (clr_flag !== 4'h0) begin n_fail++;
      $display("FAIL flush_hs_clr: got %h want 0", clr_flag); end
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_hs_valid: got %b want 0", out_valid); end
    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_idle: got ready=%b valid=%b want 1 0", req_ready, out_valid); end
  endtask

  task automatic test_priv;
    logic rdy, tk, ft;
    bit got;
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      ref_decide(4'hF, {31'h0, 1'(m)}, tk, ft);
      send_req(4'hF, 32'h80, 16'h2, 1'b1, {31'h0, 1'(m)}, rdy);
      wait_valid(got);
      n_tests++; if (!got || out_taken !== tk || out_fault !== ft) begin n_fail++;
        $display("FAIL priv_mode%0d: got t=%b f=%b want %b %b", m, out_taken, out_fault, tk, ft); end
      n_tests++; if (clr_flag !== (tk ? 4'hF : 4'h0)) begin n_fail++;
        $display("FAIL priv_clr%0d: got %h want %h", m, clr_flag, tk ? 4'hF : 4'h0); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic rdy;
    send_req(4'hE, 32'h300, 16'h0, 1'b1, 32'h0, rdy);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || req_ready !== 1'b1 || out_target !== 32'h0) begin n_fail++;
      $display("FAIL reset_mid: got v=%b r=%b tgt=%h want 0 1 0", out_valid, req_ready, out_target); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic rdy;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_req(4'hE, 32'(k * 16), 16'h0, 1'b0, 32'h0, rdy);
      n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", k, rdy); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++;
        $display("FAIL b2b_eval%0d: got v=%b r=%b want 0 0", k, out_valid, req_ready); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_target !== 32'(k * 16 + 4)) begin n_fail++;
        $display("FAIL b2b_issue%0d: got v=%b tgt=%h want 1 %h", k, out_valid, out_target, k * 16 + 4); end
      @(posedge clk); #1;
      n_tests++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
        $display("FAIL b2b_idle%0d: got r=%b v=%b want 1 0", k, req_ready, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_all_codes();
    test_flag_timing();
    test_stall_consume();
    test_wrap();
    test_flush();
    test_priv();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
